// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I datapath: sequences fetch/decode/execute/mem/writeback,
// counts retired instructions and latches a sticky trap on unsupported encodings.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       immsrc,
    output logic [2:0]       aluop,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t     state, next_state;
    logic       pcwrite_c, irwrite_c, memwrite_c, regwrite_c;
    logic [2:0] alu_f3;
    logic       f3_alu_ok, r_f7_ok, br_inv, retire;

    // ALU function and legality derived from the IR fields
    always_comb begin
        alu_f3 = ALU_ADD;
        case (func3)
            3'b111:  alu_f3 = ALU_AND;
            3'b110:  alu_f3 = ALU_OR;
            3'b100:  alu_f3 = ALU_XOR;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            default: alu_f3 = ALU_ADD;
        endcase
        f3_alu_ok = (func3 != 3'b001) && (func3 != 3'b101);
        r_f7_ok   = (func7 == 7'b0000000) || ((func7 == 7'b0100000) && (func3 == 3'b000));
        br_inv    = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state = state;
        pcwrite_c  = 1'b0;
        adrsrc     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        immsrc     = IMM_I;
        aluop      = ALU_ADD;
        case (state)
            S_FETCH: begin
                irwrite_c  = 1'b1;
                pcwrite_c  = 1'b1;
                alusrcb    = 2'b10;
                resultsrc  = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = (func3 == 3'b010) ? S_MEMADR : S_TRAP;
                    OP_R:    next_state = (f3_alu_ok && r_f7_ok) ? S_EXECR : S_TRAP;
                    OP_I:    next_state = f3_alu_ok ? S_EXECI : S_TRAP;
                    OP_BR:   next_state = (func3[2:1] != 2'b01) ? S_BRANCH : S_TRAP;
                    OP_JAL:  next_state = S_JAL;
                    OP_JALR: next_state = S_JALR;
                    OP_LUI:  next_state = S_LUI;
                    default: next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                immsrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECR: begin
                alusrca    = 2'b10;
                aluop      = ((func3 == 3'b000) && func7[5]) ? ALU_SUB : alu_f3;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                aluop      = alu_f3;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 2'b10;
                case (func3[2:1])
                    2'b10:   aluop = ALU_SLT;
                    2'b11:   aluop = ALU_SLTU;
                    default: aluop = ALU_SUB;
                endcase
                pcwrite_c  = zero ^ br_inv;
                next_state = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                pcwrite_c  = 1'b1;
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                next_state = S_JALR2;
            end
            S_LUI: begin
                alusrcb    = 2'b01;
                immsrc     = IMM_U;
                aluop      = ALU_PASSB;
                next_state = S_ALUWB;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    // Enables drop the moment reset asserts, even mid-cycle
    assign pcwrite  = pcwrite_c  & ~rst;
    assign irwrite  = irwrite_c  & ~rst;
    assign memwrite = memwrite_c & ~rst;
    assign regwrite = regwrite_c & ~rst;

    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                    (state == S_ALUWB) || (state == S_BRANCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) illegal <= 1'b1;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words are queued
// by the stimulus and checked on the falling edge by an independent monitor.
module tb_multicycle_controller;
    logic        clk, rst, zero;
    logic [6:0]  op, func7;
    logic [2:0]  func3;
    logic        pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb;
    logic [2:0]  immsrc, aluop;
    logic [31:0] instret;
    logic        pcwrite2, adrsrc2, irwrite2, memwrite2, regwrite2, illegal2;
    logic [1:0]  resultsrc2, alusrca2, alusrcb2;
    logic [2:0]  immsrc2, aluop2;
    logic [1:0]  instret2;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .pcwrite(pcwrite), .adrsrc(adrsrc), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .immsrc(immsrc), .aluop(aluop), .illegal(illegal), .instret(instret));

    multicycle_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .pcwrite(pcwrite2), .adrsrc(adrsrc2), .irwrite(irwrite2), .memwrite(memwrite2),
        .regwrite(regwrite2), .resultsrc(resultsrc2), .alusrca(alusrca2), .alusrcb(alusrcb2),
        .immsrc(immsrc2), .aluop(aluop2), .illegal(illegal2), .instret(instret2));

    typedef struct {
        string       tag;
        logic [17:0] ctrl;
        logic [33:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] retired = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor: one queued control word per clock cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, 64'({pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca,
                              alusrcb, immsrc, aluop, illegal}), 64'(e.ctrl));
            check({e.tag, "/instret"}, 64'({instret2, instret}), 64'(e.cnt));
        end
    end

    task automatic push(input string tag, input logic pcw, adr, irw, memw, regw,
                        input logic [1:0] res, sa, sb, input logic [2:0] imm, alu,
                        input logic ill);
        exp_t e;
        e.tag  = tag;
        e.ctrl = {pcw, adr, irw, memw, regw, res, sa, sb, imm, alu, ill};
        e.cnt  = {retired[1:0], retired};
        q.push_back(e);
    endtask

    task automatic push_fetch(input string tag);
        push({tag, "/fetch"}, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    endtask

    task automatic push_decode(input string tag, input logic is_jal);
        push({tag, "/decode"}, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01,
             is_jal ? 3'b011 : 3'b010, 3'b000, 0);
    endtask

    task automatic push_aluwb(input string tag);
        push({tag, "/aluwb"}, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z);
        op = o; func3 = f3; func7 = f7; zero = z;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_r(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [2:0] alu);
        set_ir(7'b0110011, f3, f7, 0);
        push_fetch(tag); push_decode(tag, 0);
        push({tag, "/execr"}, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
        push_aluwb(tag);
        cycles(4); retired++;
    endtask

    task automatic run_i(input string tag, input logic [2:0] f3, input logic [2:0] alu);
        set_ir(7'b0010011, f3, 7'b0100000, 0);
        push_fetch(tag); push_decode(tag, 0);
        push({tag, "/execi"}, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0);
        push_aluwb(tag);
        cycles(4); retired++;
    endtask

    task automatic run_lw();
        set_ir(7'b0000011, 3'b010, 7'd0, 0);
        push_fetch("lw"); push_decode("lw", 0);
        push("lw/memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
        push("lw/memread", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        push("lw/memwb", 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        cycles(5); retired++;
    endtask

    task automatic run_sw();
        set_ir(7'b0100011, 3'b010, 7'd0, 0);
        push_fetch("sw"); push_decode("sw", 0);
        push("sw/memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0);
        push("sw/memwrite", 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        cycles(4); retired++;
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3, input logic z,
                          input logic [2:0] alu, input logic pcw);
        set_ir(7'b1100011, f3, 7'd0, z);
        push_fetch(tag); push_decode(tag, 0);
        push({tag, "/branch"}, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
        cycles(3); retired++;
    endtask

    task automatic run_lui();
        set_ir(7'b0110111, 3'b000, 7'd0, 0);
        push_fetch("lui"); push_decode("lui", 0);
        push("lui/lui", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 3'b111, 0);
        push_aluwb("lui");
        cycles(4); retired++;
    endtask

    task automatic run_jal();
        set_ir(7'b1101111, 3'b000, 7'd0, 0);
        push_fetch("jal"); push_decode("jal", 1);
        push("jal/jal", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);
        push_aluwb("jal");
        cycles(4); retired++;
    endtask

    task automatic run_jalr();
        set_ir(7'b1100111, 3'b000, 7'd0, 0);
        push_fetch("jalr"); push_decode("jalr", 0);
        push("jalr/jalr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
        push("jalr/jalr2", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);
        push_aluwb("jalr");
        cycles(5); retired++;
    endtask

    task automatic run_trap(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic [6:0] f7, input int hold);
        set_ir(o, f3, f7, 1);
        push_fetch(tag); push_decode(tag, 0);
        for (int i = 0; i < hold; i++)
            push({tag, "/trap"}, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1);
        cycles(2 + hold);
    endtask

    // Called just after a rising edge; leaves the DUT in FETCH just after the next edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "/enables"}, 64'({pcwrite, irwrite, memwrite, regwrite}), 64'(0));
        check({tag, "/illegal"}, 64'(illegal), 64'(0));
        check({tag, "/instret"}, 64'({instret2, instret}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired = 0;
    endtask

    initial begin
        rst = 1'b1;
        set_ir(7'd0, 3'd0, 7'd0, 0);
        @(posedge clk);
        #1;
        do_reset("por");

        run_r("add", 3'b000, 7'b0000000, 3'b000);
        run_r("sub", 3'b000, 7'b0100000, 3'b001);
        run_r("and", 3'b111, 7'b0000000, 3'b010);
        run_r("sltu", 3'b011, 7'b0000000, 3'b110);
        run_lw();
        run_sw();
        run_i("xori", 3'b100, 3'b100);
        run_i("slti", 3'b010, 3'b101);
        run_br("beq_t", 3'b000, 1, 3'b001, 1);
        run_br("bne_nt", 3'b001, 1, 3'b001, 0);
        run_br("blt_t", 3'b100, 0, 3'b101, 1);
        run_br("bgeu_t", 3'b111, 1, 3'b110, 1);
        run_lui();
        run_jal();
        run_jalr();

        // Reset in the middle of a store
        set_ir(7'b0100011, 3'b010, 7'd0, 0);
        push_fetch("swrst"); push_decode("swrst", 0);
        push("swrst/memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0);
        cycles(3);
        #1;
        check("swrst/memwrite_hi", 64'(memwrite), 64'(1));
        rst = 1'b1;
        #1;
        check("swrst/memwrite_lo", 64'({pcwrite, irwrite, memwrite, regwrite}), 64'(0));
        check("swrst/instret", 64'({instret2, instret}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired = 0;

        // Five retirements wrap the 2-bit counter: 1,2,3,0,1
        for (int i = 0; i < 5; i++) run_i("addi", 3'b000, 3'b000);

        run_trap("trap_op", 7'b1111111, 3'b000, 7'd0, 20);
        do_reset("trap_clr");
        run_trap("trap_r_f7", 7'b0110011, 3'b111, 7'b0100000, 3);
        do_reset("trap_clr2");
        run_trap("trap_lw_f3", 7'b0000011, 3'b000, 7'd0, 3);
        do_reset("trap_clr3");
        run_trap("trap_shift", 7'b0010011, 3'b001, 7'd0, 2);
        do_reset("trap_clr4");
        run_r("or", 3'b110, 7'b0000000, 3'b011);

        push_fetch("final");
        cycles(1);
        check("queue_drained", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
